// File: rtl/cache_resp_buffer.sv
// Cache response buffer: a DEPTH-entry FIFO of {hit, address, data} records with
// valid/ready flow control, freeze, flush and occupancy. Define CACHE_RESP_BYPASS_EN for the zero-latency empty bypass.
module cache_resp_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   hit_i,
  input  logic [ADDR_W-1:0]      address_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   hit_o,
  output logic [ADDR_W-1:0]      address_o,
  output logic [DATA_W-1:0]      data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          in_rec;
  rec_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          bypass;
  logic          push, pop, wr_en, rd_en;

  assign in_rec = '{hit: hit_i, addr: address_i, data: data_i};
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

`ifdef CACHE_RESP_BYPASS_EN
  // An arriving record is presented straight to the head while the buffer is empty.
  assign bypass = empty & in_valid_i & ~enable_ni & ~flush_i & rst_ni;
`else
  assign bypass = 1'b0;
`endif

  // Ready ignores out_ready_i, so a full buffer never accepts even when it pops.
  assign in_ready_o  = rst_ni & ~full & ~enable_ni & ~flush_i;
  assign out_valid_o = (~empty & ~enable_ni) | bypass;

  assign push  = in_valid_i & in_ready_o;
  assign pop   = out_valid_o & out_ready_i;
  // A bypassed record taken by downstream never touches the storage.
  assign wr_en = push & ~(bypass & out_ready_i);
  assign rd_en = pop & ~bypass;

  // NOTE: storage has an async reset so no stale record can reappear after reset;
  // the loop is fine here because every entry gets a constant in the reset branch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= in_rec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: head gets a default before any branch so this block cannot infer a latch.
  always_comb begin
    head = '0;
    if (!empty)      head = mem[rd_ptr];
    else if (bypass) head = in_rec;
  end

  assign hit_o     = head.hit;
  assign address_o = head.addr;
  assign data_o    = head.data;
  assign count_o   = count;
  assign full_o    = full;
  assign empty_o   = empty;

endmodule
